// File: rtl/game_pkg.sv
// Shared definitions for the level-progression interface: level codes exchanged
// with the level FSM and the status controller's state encoding.
package game_pkg;

    localparam logic [1:0] LVL1_CODE      = 2'b00;
    localparam logic [1:0] LVL2_CODE      = 2'b01;
    localparam logic [1:0] WIN_CODE       = 2'b10;
    localparam logic [1:0] GAME_OVER_CODE = 2'b11;

    typedef enum logic [2:0] {
        PLAY,
        INVULN,
        FINISH_REQ,
        DEAD,
        DONE
    } status_state_t;

    // Increment that sticks at the ceiling instead of wrapping.
    function automatic logic [2:0] sat_inc3(input logic [2:0] value, input logic [2:0] ceiling);
        return (value >= ceiling) ? value : value + 3'd1;
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Loadable down-counter stepped by a frame tick; flags the tick that empties it.
module frame_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             tick_i,
    output logic             zero_o,
    output logic             last_tick_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        // NOTE: non-blocking so every register updates from pre-edge values.
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o      = (count_q == '0);
    assign last_tick_o = tick_i && (count_q == WIDTH'(1));

endmodule

// File: rtl/game_status_ctrl.sv
// Lives, hit immunity and goal dwell; raises finishFlag once per level and holds
// it until the level FSM acknowledges by changing levelCode.
module game_status_ctrl
    import game_pkg::*;
#(
    parameter int INIT_LIVES        = 3,
    parameter int MAX_LIVES         = 5,
    parameter int INVULN_FRAMES     = 60,
    parameter int GOAL_DWELL_FRAMES = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       playerHitHazard,
    input  logic       playerAtGoal,
    input  logic       extraLife,
    input  logic [1:0] levelCode,
    input  logic       levelUp,
    output logic       gameOver,
    output logic       finishFlag,
    output logic [2:0] lives,
    output logic       invulnerable,
    output logic [1:0] levelsCleared
);

    localparam int TW = $clog2(INVULN_FRAMES + 1);
    localparam int DW = $clog2(GOAL_DWELL_FRAMES + 1);

    status_state_t state_q, state_d;

    logic [2:0]    lives_q, lives_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    code_q, code_d;
    logic [1:0]    cleared_q, cleared_d;
    logic          game_over_q, game_over_d;
    logic          finish_q, finish_d;
    logic          invuln_q, invuln_d;

    logic dwell_active;
    logic goal_reached;
    logic capture;
    logic timer_load;
    logic timer_zero;
    logic timer_expire;

    frame_counter #(
        .WIDTH (TW)
    ) u_invuln_timer (
        .clk         (clk),
        .resetN      (resetN),
        .clear_i     (state_d != INVULN),
        .load_i      (timer_load),
        .load_val_i  (TW'(INVULN_FRAMES)),
        .tick_i      (startOfFrame && (state_q == INVULN)),
        .zero_o      (timer_zero),
        .last_tick_o (timer_expire)
    );

    // Goal dwell: counts frames spent at the goal; goalReached is the one step onto the ceiling.
    assign dwell_active = (state_q == PLAY) || (state_q == INVULN);
    assign goal_reached = dwell_active && startOfFrame && playerAtGoal &&
                          (dwell_q == DW'(GOAL_DWELL_FRAMES - 1));

    always_comb begin
        dwell_d = dwell_q;
        if (!dwell_active) begin
            dwell_d = '0;
        end else if (startOfFrame) begin
            if (!playerAtGoal) begin
                dwell_d = '0;
            end else if (dwell_q != DW'(GOAL_DWELL_FRAMES)) begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= PLAY;
            lives_q     <= 3'(INIT_LIVES);
            dwell_q     <= '0;
            code_q      <= LVL1_CODE;
            cleared_q   <= '0;
            game_over_q <= 1'b0;
            finish_q    <= 1'b0;
            invuln_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            dwell_q     <= dwell_d;
            code_q      <= code_d;
            cleared_q   <= cleared_d;
            game_over_q <= game_over_d;
            finish_q    <= finish_d;
            invuln_q    <= invuln_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            PLAY: begin
                if (playerHitHazard) begin
                    if ((lives_q == 3'd1) && !extraLife) begin
                        state_d = DEAD;
                    end else begin
                        state_d    = INVULN;
                        timer_load = 1'b1;
                    end
                end else if (goal_reached) begin
                    state_d = FINISH_REQ;
                    capture = 1'b1;
                end
            end
            INVULN: begin
                if (goal_reached) begin
                    state_d = FINISH_REQ;
                    capture = 1'b1;
                end else if (timer_expire || timer_zero) begin
                    state_d = PLAY;
                end
            end
            FINISH_REQ: begin
                // The acknowledgement is any change of code; codes without a meaning here keep waiting.
                if (levelCode != code_q) begin
                    case (levelCode)
                        LVL2_CODE:      state_d = PLAY;
                        WIN_CODE:       state_d = DONE;
                        GAME_OVER_CODE: state_d = DEAD;
                        default:        state_d = FINISH_REQ;
                    endcase
                end
            end
            DEAD, DONE: state_d = state_q;
            default:    state_d = PLAY;
        endcase
        if ((levelCode == GAME_OVER_CODE) && (state_q != DONE)) begin
            state_d = DEAD;
        end
    end

    always_comb begin
        lives_d     = lives_q;
        code_d      = code_q;
        cleared_d   = cleared_q;
        game_over_d = (state_d == DEAD);
        finish_d    = (state_d == FINISH_REQ);
        invuln_d    = (state_d == INVULN);

        if (capture) begin
            code_d = levelCode;
        end

        // A pickup in the same cycle as an accepted hit cancels it out.
        if (state_d == DEAD) begin
            lives_d = '0;
        end else if ((state_q == PLAY) && playerHitHazard) begin
            lives_d = extraLife ? lives_q : lives_q - 3'd1;
        end else if (dwell_active && extraLife) begin
            lives_d = sat_inc3(lives_q, 3'(MAX_LIVES));
        end

        if (levelUp && (cleared_q != 2'd3)) begin
            cleared_d = cleared_q + 2'd1;
        end
    end

    assign gameOver      = game_over_q;
    assign finishFlag    = finish_q;
    assign lives         = lives_q;
    assign invulnerable  = invuln_q;
    assign levelsCleared = cleared_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed bench for game_status_ctrl: a frame-level model of lives, immunity and
// goal dwell is compared every cycle, plus hand-computed checkpoints.
module tb_game_status_ctrl;
    import game_pkg::*;

    localparam int INIT_LIVES = 3;
    localparam int MAX_LIVES  = 5;
    localparam int INV_FRAMES = 60;
    localparam int DWELL      = 4;

    logic       clk             = 1'b0;
    logic       resetN          = 1'b0;
    logic       startOfFrame    = 1'b0;
    logic       playerHitHazard = 1'b0;
    logic       playerAtGoal    = 1'b0;
    logic       extraLife       = 1'b0;
    logic [1:0] levelCode       = LVL1_CODE;
    logic       levelUp         = 1'b0;
    logic       gameOver;
    logic       finishFlag;
    logic [2:0] lives;
    logic       invulnerable;
    logic [1:0] levelsCleared;

    int n_checks = 0;
    int n_errors = 0;

    // Model: lives count, frames of immunity left, frames at goal, level-exit flags.
    int         m_lives;
    int         m_inv_left;
    int         m_dwell;
    int         m_cleared;
    bit         m_dead;
    bit         m_done;
    bit         m_fin;
    logic [1:0] m_cap;

    always #5 clk = ~clk;

    game_status_ctrl #(
        .INIT_LIVES        (INIT_LIVES),
        .MAX_LIVES         (MAX_LIVES),
        .INVULN_FRAMES     (INV_FRAMES),
        .GOAL_DWELL_FRAMES (DWELL)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .playerHitHazard (playerHitHazard),
        .playerAtGoal    (playerAtGoal),
        .extraLife       (extraLife),
        .levelCode       (levelCode),
        .levelUp         (levelUp),
        .gameOver        (gameOver),
        .finishFlag      (finishFlag),
        .lives           (lives),
        .invulnerable    (invulnerable),
        .levelsCleared   (levelsCleared)
    );

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_lives    = INIT_LIVES;
        m_inv_left = 0;
        m_dwell    = 0;
        m_cleared  = 0;
        m_dead     = 1'b0;
        m_done     = 1'b0;
        m_fin      = 1'b0;
        m_cap      = LVL1_CODE;
    endtask

    task automatic model_kill();
        m_dead     = 1'b1;
        m_lives    = 0;
        m_fin      = 1'b0;
        m_inv_left = 0;
    endtask

    task automatic model_step();
        bit goal;
        if (levelUp && (m_cleared < 3)) m_cleared++;
        if (m_dead || m_done) return;
        if (levelCode == GAME_OVER_CODE) begin
            model_kill();
            return;
        end
        if (m_fin) begin
            m_dwell = 0;
            if ((levelCode != m_cap) && (levelCode == LVL2_CODE)) begin
                m_fin = 1'b0;
            end else if ((levelCode != m_cap) && (levelCode == WIN_CODE)) begin
                m_fin  = 1'b0;
                m_done = 1'b1;
            end
            return;
        end
        goal = startOfFrame && playerAtGoal && (m_dwell == DWELL - 1);
        if (startOfFrame) m_dwell = playerAtGoal ? ((m_dwell < DWELL) ? m_dwell + 1 : DWELL) : 0;
        if (playerHitHazard && (m_inv_left == 0)) begin
            if ((m_lives == 1) && !extraLife) begin
                model_kill();
            end else begin
                if (!extraLife) m_lives--;
                m_inv_left = INV_FRAMES;
            end
        end else begin
            if (extraLife && (m_lives < MAX_LIVES)) m_lives++;
            if (goal) begin
                m_fin      = 1'b1;
                m_cap      = levelCode;
                m_inv_left = 0;
            end else if (startOfFrame && (m_inv_left > 0)) begin
                m_inv_left--;
            end
        end
    endtask

    // Model advance and per-cycle comparison, 2 time units after each active edge.
    initial begin : model_compare
        model_reset();
        forever begin
            @(posedge clk);
            if (!resetN) model_reset();
            else model_step();
            #2;
            check("cyc gameOver",      8'(gameOver),      8'(m_dead));
            check("cyc finishFlag",    8'(finishFlag),    8'(m_fin));
            check("cyc lives",         8'(lives),         8'(m_lives));
            check("cyc invulnerable",  8'(invulnerable),  8'(m_inv_left > 0));
            check("cyc levelsCleared", 8'(levelsCleared), 8'(m_cleared));
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic drive(input bit s, input bit h, input bit g, input bit x);
        @(negedge clk);
        startOfFrame    = s;
        playerHitHazard = h;
        playerAtGoal    = g;
        extraLife       = x;
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    task automatic frames(input int n, input bit g);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, g, 1'b0);
            drive(1'b0, 1'b0, g, 1'b0);
        end
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        resetN    = 1'b0;
        levelCode = LVL1_CODE;
        levelUp   = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin : stimulus
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Reset values.
        settle();
        check("reset lives",         8'(lives),         8'd3);
        check("reset gameOver",      8'(gameOver),      8'd0);
        check("reset finishFlag",    8'(finishFlag),    8'd0);
        check("reset invulnerable",  8'(invulnerable),  8'd0);
        check("reset levelsCleared", 8'(levelsCleared), 8'd0);

        // L1: four frames at goal raise finishFlag; 00->01 acknowledges.
        frames(3, 1'b1);
        settle();
        check("l1 finish after 3 frames", 8'(finishFlag), 8'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        settle();
        check("l1 finish after 4 frames", 8'(finishFlag), 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        levelCode = LVL2_CODE;
        levelUp   = 1'b1;
        settle();
        check("l1 ack finishFlag", 8'(finishFlag),    8'd0);
        check("l1 ack lives",      8'(lives),         8'd3);
        check("l1 ack cleared",    8'(levelsCleared), 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        levelUp = 1'b0;

        // L2: finish, then win code; DONE ignores hits and pickups.
        frames(4, 1'b1);
        settle();
        check("l2 finishFlag", 8'(finishFlag), 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        levelCode = WIN_CODE;
        settle();
        check("win finishFlag drop", 8'(finishFlag), 8'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("done lives frozen",  8'(lives),    8'd3);
        check("done gameOver",      8'(gameOver), 8'd0);

        // Three well-spaced hits: 2, 1, then death.
        apply_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("hit1 lives",  8'(lives),        8'd2);
        check("hit1 invuln", 8'(invulnerable), 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        frames(59, 1'b0);
        settle();
        check("invuln at 59 frames", 8'(invulnerable), 8'd1);
        frames(1, 1'b0);
        settle();
        check("invuln at 60 frames", 8'(invulnerable), 8'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("hit2 lives", 8'(lives), 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        frames(60, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("hit3 lives",    8'(lives),        8'd0);
        check("hit3 gameOver", 8'(gameOver),     8'd1);
        check("hit3 invuln",   8'(invulnerable), 8'd0);

        // Second hit 10 frames into immunity is ignored; immunity lasts 60 frames from the first.
        apply_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        frames(10, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("ignored hit lives",  8'(lives),        8'd2);
        check("ignored hit invuln", 8'(invulnerable), 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        frames(49, 1'b0);
        settle();
        check("invuln 59 after hit", 8'(invulnerable), 8'd1);
        frames(1, 1'b0);
        settle();
        check("invuln 60 after hit", 8'(invulnerable), 8'd0);

        // Last life: hit plus pickup in the same cycle nets to no change.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        frames(60, 1'b0);
        settle();
        check("one life left", 8'(lives), 8'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        settle();
        check("hit+pickup lives",    8'(lives),        8'd1);
        check("hit+pickup invuln",   8'(invulnerable), 8'd1);
        check("hit+pickup gameOver", 8'(gameOver),     8'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        frames(60, 1'b0);

        // Pickups saturate at MAX_LIVES.
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("pickup saturation", 8'(lives), 8'd5);

        // Hit beats goal in the same cycle; goal later reached from INVULN.
        apply_reset();
        frames(3, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        check("hit+goal lives",  8'(lives),        8'd2);
        check("hit+goal invuln", 8'(invulnerable), 8'd1);
        check("hit+goal finish", 8'(finishFlag),   8'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        frames(1, 1'b0);
        frames(4, 1'b1);
        settle();
        check("invuln goal finish", 8'(finishFlag),   8'd1);
        check("invuln goal clears", 8'(invulnerable), 8'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        settle();
        check("finish_req ignores hit/pickup", 8'(lives), 8'd2);

        // Asynchronous reset during FINISH_REQ takes effect before the next edge.
        @(negedge clk);
        resetN          = 1'b0;
        startOfFrame    = 1'b0;
        playerHitHazard = 1'b0;
        playerAtGoal    = 1'b0;
        extraLife       = 1'b0;
        #1;
        check("async reset finish", 8'(finishFlag), 8'd0);
        check("async reset lives",  8'(lives),      8'd3);
        @(negedge clk);
        resetN = 1'b1;

        // levelsCleared saturates; game-over code overrides PLAY.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            levelUp = 1'b1;
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            levelUp = 1'b0;
        end
        settle();
        check("levelsCleared saturation", 8'(levelsCleared), 8'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        levelCode = GAME_OVER_CODE;
        settle();
        check("override gameOver", 8'(gameOver),   8'd1);
        check("override lives",    8'(lives),      8'd0);
        check("override finish",   8'(finishFlag), 8'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
